sys_sequencer: RTL and testbench
================================

SYS_SEQUENCER -- requirements
Module: sys_sequencer

Interface
REQ-001 Parameter ROWS, 5, number of systolic-array PE rows (weight rows loaded per job).
REQ-002 Parameter COLS, 3, number of systolic-array PE columns (result lanes).
REQ-003 Parameter NUM_VEC, 8, activation vectors streamed per job.
REQ-004 Derived constant PIPE_LAT = ROWS+COLS-1: activation-in to result-out latency of the array, in cycles.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  job request; sampled only in IDLE.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 ready  out  1  one-cycle pulse marking job completion.
REQ-011 acc_clr  out  1  clears array accumulators; one-cycle pulse.
REQ-012 w_load  out  1  weight-row write enable to the array.
REQ-013 w_addr  out  $clog2(ROWS)  weight buffer read address and target row.
REQ-014 a_valid  out  1  activation vector valid into the array.
REQ-015 a_addr  out  $clog2(NUM_VEC)  activation buffer read address.
REQ-016 out_valid  out  1  array result lanes hold a valid COLS x 24-bit result.
REQ-017 out_addr  out  $clog2(NUM_VEC)  result buffer write address.

Function
REQ-018 FSM states SHALL be IDLE, LOAD_W, STREAM, DRAIN and DONE; each state SHALL be encoded exactly once.
REQ-019 IDLE->LOAD_W SHALL occur when start=1 at a rising edge; start SHALL be ignored in all other states.
REQ-020 LOAD_W SHALL last exactly ROWS cycles, with w_load=1 and w_addr=0..ROWS-1 in consecutive cycles; it SHALL then go to STREAM.
REQ-021 acc_clr SHALL be 1 only in the first LOAD_W cycle.
REQ-022 STREAM SHALL last exactly NUM_VEC cycles, with a_valid=1 and a_addr=0..NUM_VEC-1 in consecutive cycles; it SHALL then go to DRAIN.
REQ-023 DRAIN SHALL last exactly PIPE_LAT cycles; it SHALL then go to DONE.
REQ-024 out_valid SHALL be 1 for exactly NUM_VEC consecutive cycles, the first being PIPE_LAT cycles after the first a_valid cycle; out_addr SHALL step 0..NUM_VEC-1 across that window. The window spans the STREAM/DRAIN boundary.
REQ-025 DONE SHALL last one cycle with ready=1; it SHALL then go to IDLE unconditionally.
REQ-026 If start=1 while in DONE, it SHALL be ignored; a new job SHALL need start=1 sampled in IDLE.
REQ-027 Outputs SHALL be registered, with no combinational path from start to any output.
REQ-028 Outside the windows in REQ-020..REQ-025, w_load, a_valid, out_valid, acc_clr and ready SHALL be 0, and all address outputs SHALL be 0.
REQ-029 Counters SHALL wrap to 0 at their terminal count and SHALL NOT exceed ROWS-1 or NUM_VEC-1.
REQ-030 Total job length SHALL be ROWS+NUM_VEC+PIPE_LAT+1 cycles, counted from the start-sampling edge to the end of DONE.

Reset
REQ-031 With rst=1 at a rising edge, the state SHALL become IDLE and all counters 0.
REQ-032 After reset, all outputs SHALL read 0.
REQ-033 Reset SHALL take priority over start and over any in-progress job; a job aborted by rst SHALL NOT produce ready.
REQ-034 With rst and start both 1 on the same edge, the block SHALL stay in IDLE.

Verification
REQ-035 Defaults (ROWS=5, COLS=3, NUM_VEC=8, PIPE_LAT=7), start pulsed and sampled at edge 0 (cycle n = n-th cycle after it) -> required response:
  - w_load=1 in cycles 1-5, w_addr 0..4.
  - acc_clr=1 in cycle 1 only.
  - a_valid=1 in cycles 6-13, a_addr 0..7.
  - out_valid=1 in cycles 13-20, out_addr 0..7.
  - ready=1 in cycle 21 only.
  - busy=1 in cycles 1-21; busy=0 in cycle 22.
REQ-036 start held high continuously -> jobs run back-to-back with one IDLE cycle between jobs: DONE at cycle 21, IDLE at 22, second job's LOAD_W starting at cycle 23; every job shows identical timing.
REQ-037 start pulsed again in cycles 3, 10 and 21 of a running job -> no effect on the sequence; exactly one ready per sampled-in-IDLE start.
REQ-038 rst asserted in cycle 9 (mid-STREAM) -> next cycle all outputs 0, busy=0; no ready; a subsequent start gives the full REQ-035 timing.
REQ-039 rst=1 together with start=1 -> stays IDLE, outputs 0; start=1 on the following edge with rst=0 -> job begins.
REQ-040 Parameter sweep ROWS=1, NUM_VEC=1, COLS=1 -> one cycle each of w_load, a_valid, out_valid; PIPE_LAT=1; out_valid in the cycle after a_valid; ready at cycle 4.

Source files
------------

// File: rtl/sys_sequencer.sv
// Control sequencer for a ROWS x COLS systolic array. A job runs in four phases:
// weight load, activation stream, pipeline drain, then a one-cycle completion pulse.
module sys_sequencer #(
  parameter int ROWS    = 5,
  parameter int COLS    = 3,
  parameter int NUM_VEC = 8,
  localparam int W_AW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int A_AW   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            ready,
  output logic            acc_clr,
  output logic            w_load,
  output logic [W_AW-1:0] w_addr,
  output logic            a_valid,
  output logic [A_AW-1:0] a_addr,
  output logic            out_valid,
  output logic [A_AW-1:0] out_addr
);

  localparam int PIPE_LAT = ROWS + COLS - 1;
  // One phase counter serves every state; wide enough to also hold the
  // position inside the combined stream+drain window.
  localparam int CW = $clog2(ROWS + NUM_VEC + PIPE_LAT + 1);

  localparam logic [CW-1:0] ROWS_LAST = CW'(ROWS - 1);
  localparam logic [CW-1:0] VEC_LAST  = CW'(NUM_VEC - 1);
  localparam logic [CW-1:0] PIPE_LAST = CW'(PIPE_LAT - 1);
  localparam logic [CW-1:0] VEC_N     = CW'(NUM_VEC);
  localparam logic [CW-1:0] PIPE_N    = CW'(PIPE_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;

  logic            busy_d, ready_d, acc_clr_d, w_load_d, a_valid_d, out_valid_d;
  logic [W_AW-1:0] w_addr_d;
  logic [A_AW-1:0] a_addr_d, out_addr_d;
  logic [CW-1:0]   pos_nx;
  logic            in_window;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_LOAD_W;
      S_LOAD_W: if (cnt == ROWS_LAST) state_nx = S_STREAM;
                else                  cnt_nx   = cnt + CW'(1);
      S_STREAM: if (cnt == VEC_LAST)  state_nx = S_DRAIN;
                else                  cnt_nx   = cnt + CW'(1);
      S_DRAIN:  if (cnt == PIPE_LAST) state_nx = S_DONE;
                else                  cnt_nx   = cnt + CW'(1);
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered, so each
  // output flop already holds the value for the cycle the state register enters.
  always_comb begin
    busy_d      = (state_nx != S_IDLE);
    ready_d     = 1'b0;
    acc_clr_d   = 1'b0;
    w_load_d    = 1'b0;
    w_addr_d    = '0;
    a_valid_d   = 1'b0;
    a_addr_d    = '0;
    out_valid_d = 1'b0;
    out_addr_d  = '0;
    pos_nx      = '0;
    in_window   = 1'b0;
    unique case (state_nx)
      S_LOAD_W: begin
        w_load_d  = 1'b1;
        w_addr_d  = W_AW'(cnt_nx);
        acc_clr_d = (cnt_nx == '0);
      end
      S_STREAM: begin
        a_valid_d = 1'b1;
        a_addr_d  = A_AW'(cnt_nx);
        pos_nx    = cnt_nx;
        in_window = 1'b1;
      end
      S_DRAIN: begin
        pos_nx    = VEC_N + cnt_nx;
        in_window = 1'b1;
      end
      S_DONE:   ready_d = 1'b1;
      default:  ;
    endcase
    // Results emerge PIPE_LAT cycles behind the activations, so the result
    // window is the last NUM_VEC cycles of stream+drain.
    if (in_window && (pos_nx >= PIPE_N)) begin
      out_valid_d = 1'b1;
      out_addr_d  = A_AW'(pos_nx - PIPE_N);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      ready     <= 1'b0;
      acc_clr   <= 1'b0;
      w_load    <= 1'b0;
      w_addr    <= '0;
      a_valid   <= 1'b0;
      a_addr    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
    end else begin
      busy      <= busy_d;
      ready     <= ready_d;
      acc_clr   <= acc_clr_d;
      w_load    <= w_load_d;
      w_addr    <= w_addr_d;
      a_valid   <= a_valid_d;
      a_addr    <= a_addr_d;
      out_valid <= out_valid_d;
      out_addr  <= out_addr_d;
    end
  end

  // Weight load and activation streaming are mutually exclusive phases.
  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(w_load && a_valid));
  a_ready_idle: assert property (@(posedge clk) disable iff (rst) ready |-> !(w_load || a_valid || out_valid));

endmodule

// File: tb/tb_sys_sequencer.sv
// Self-checking bench for sys_sequencer: default instance plus a 1x1x1 instance,
// both driven by the same stimulus and checked against a cycle-index reference model.
module tb_sys_sequencer;

  localparam int R_B = 5, C_B = 3, V_B = 8;
  localparam int P_B = R_B + C_B - 1;
  localparam int T_B = R_B + V_B + P_B + 1;
  localparam int R_S = 1, C_S = 1, V_S = 1;
  localparam int P_S = R_S + C_S - 1;
  localparam int T_S = R_S + V_S + P_S + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  logic       b_busy, b_ready, b_acc_clr, b_w_load, b_a_valid, b_out_valid;
  logic [2:0] b_w_addr, b_a_addr, b_out_addr;
  logic       s_busy, s_ready, s_acc_clr, s_w_load, s_a_valid, s_out_valid;
  logic [0:0] s_w_addr, s_a_addr, s_out_addr;

  sys_sequencer #(.ROWS(R_B), .COLS(C_B), .NUM_VEC(V_B)) dut_big (
    .clk(clk), .rst(rst), .start(start),
    .busy(b_busy), .ready(b_ready), .acc_clr(b_acc_clr),
    .w_load(b_w_load), .w_addr(b_w_addr),
    .a_valid(b_a_valid), .a_addr(b_a_addr),
    .out_valid(b_out_valid), .out_addr(b_out_addr)
  );

  sys_sequencer #(.ROWS(R_S), .COLS(C_S), .NUM_VEC(V_S)) dut_small (
    .clk(clk), .rst(rst), .start(start),
    .busy(s_busy), .ready(s_ready), .acc_clr(s_acc_clr),
    .w_load(s_w_load), .w_addr(s_w_addr),
    .a_valid(s_a_valid), .a_addr(s_a_addr),
    .out_valid(s_out_valid), .out_addr(s_out_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int busy; int ready; int acc_clr;
    int w_load; int w_addr;
    int a_valid; int a_addr;
    int out_valid; int out_addr;
  } outs_t;

  typedef struct {
    logic rst; logic start;
    int busy; int w_load; int acc_clr; int ready;
  } vec_t;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int job_b = 0, job_s = 0;        // cycle index within the current job, 0 = idle
  int mod_rdy = 0, dut_rdy = 0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s (cycle %0d): got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  // Required outputs n cycles after the start-sampling edge, straight from the job timeline.
  function automatic outs_t expect_at(int n, int r, int v, int p);
    outs_t o;
    int t;
    o = '{default: 0};
    t = r + v + p + 1;
    o.busy    = (n >= 1 && n <= t) ? 1 : 0;
    o.acc_clr = (n == 1) ? 1 : 0;
    o.ready   = (n == t) ? 1 : 0;
    if (n >= 1 && n <= r) begin o.w_load = 1; o.w_addr = n - 1; end
    if (n > r && n <= r + v) begin o.a_valid = 1; o.a_addr = n - r - 1; end
    if (n > r + p && n <= r + p + v) begin o.out_valid = 1; o.out_addr = n - r - p - 1; end
    return o;
  endfunction

  function automatic int next_job(int j, logic r, logic s, int t);
    if (r) return 0;
    if (j == 0) return s ? 1 : 0;
    return (j == t) ? 0 : j + 1;
  endfunction

  task automatic cmp(string tag, outs_t e, outs_t a);
    check({tag, ".busy"},      a.busy,      e.busy);
    check({tag, ".ready"},     a.ready,     e.ready);
    check({tag, ".acc_clr"},   a.acc_clr,   e.acc_clr);
    check({tag, ".w_load"},    a.w_load,    e.w_load);
    check({tag, ".w_addr"},    a.w_addr,    e.w_addr);
    check({tag, ".a_valid"},   a.a_valid,   e.a_valid);
    check({tag, ".a_addr"},    a.a_addr,    e.a_addr);
    check({tag, ".out_valid"}, a.out_valid, e.out_valid);
    check({tag, ".out_addr"},  a.out_addr,  e.out_addr);
  endtask

  // Advance one clock with the current inputs and check both instances.
  task automatic tick();
    outs_t eb, es, ab, as_;
    job_b = next_job(job_b, rst, start, T_B);
    job_s = next_job(job_s, rst, start, T_S);
    @(posedge clk);
    #1;
    cyc++;
    eb = expect_at(job_b, R_B, V_B, P_B);
    es = expect_at(job_s, R_S, V_S, P_S);
    ab.busy = b_busy ? 1 : 0;       ab.ready = b_ready ? 1 : 0;
    ab.acc_clr = b_acc_clr ? 1 : 0; ab.w_load = b_w_load ? 1 : 0;
    ab.w_addr = int'(b_w_addr);     ab.a_valid = b_a_valid ? 1 : 0;
    ab.a_addr = int'(b_a_addr);     ab.out_valid = b_out_valid ? 1 : 0;
    ab.out_addr = int'(b_out_addr);
    as_.busy = s_busy ? 1 : 0;       as_.ready = s_ready ? 1 : 0;
    as_.acc_clr = s_acc_clr ? 1 : 0; as_.w_load = s_w_load ? 1 : 0;
    as_.w_addr = int'(s_w_addr);     as_.a_valid = s_a_valid ? 1 : 0;
    as_.a_addr = int'(s_a_addr);     as_.out_valid = s_out_valid ? 1 : 0;
    as_.out_addr = int'(s_out_addr);
    cmp("big", eb, ab);
    cmp("small", es, as_);
    if (eb.ready == 1) mod_rdy++;
    if (b_ready) dut_rdy++;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  vec_t vecs[6];
  int   rdy_b, rdy_s, acc_hits, acc2, nrdy;

  initial begin
    // Reset / start interaction vectors, applied from IDLE.
    vecs[0] = '{rst: 1'b1, start: 1'b1, busy: 0, w_load: 0, acc_clr: 0, ready: 0};
    vecs[1] = '{rst: 1'b0, start: 1'b1, busy: 1, w_load: 1, acc_clr: 1, ready: 0};
    vecs[2] = '{rst: 1'b0, start: 1'b0, busy: 1, w_load: 1, acc_clr: 0, ready: 0};
    vecs[3] = '{rst: 1'b1, start: 1'b0, busy: 0, w_load: 0, acc_clr: 0, ready: 0};
    vecs[4] = '{rst: 1'b0, start: 1'b0, busy: 0, w_load: 0, acc_clr: 0, ready: 0};
    vecs[5] = '{rst: 1'b0, start: 1'b1, busy: 1, w_load: 1, acc_clr: 1, ready: 0};

    do_reset();
    check("reset.busy", b_busy ? 1 : 0, 0);
    check("reset.out_addr", int'(b_out_addr), 0);

    for (int i = 0; i < 6; i++) begin
      rst = vecs[i].rst; start = vecs[i].start;
      tick();
      check($sformatf("vec%0d.busy", i),    b_busy ? 1 : 0,    vecs[i].busy);
      check($sformatf("vec%0d.w_load", i),  b_w_load ? 1 : 0,  vecs[i].w_load);
      check($sformatf("vec%0d.acc_clr", i), b_acc_clr ? 1 : 0, vecs[i].acc_clr);
      check($sformatf("vec%0d.ready", i),   b_ready ? 1 : 0,   vecs[i].ready);
    end
    do_reset();

    // Single pulsed job: ready cycle on both instances.
    rdy_b = -1; rdy_s = -1;
    for (int n = 1; n <= T_B + 1; n++) begin
      start = (n == 1);
      tick();
      if (b_ready && rdy_b < 0) rdy_b = n;
      if (s_ready && rdy_s < 0) rdy_s = n;
    end
    check("pulse.big_ready_cycle", rdy_b, T_B);
    check("pulse.small_ready_cycle", rdy_s, T_S);

    // start held high: second job's first LOAD_W cycle after one IDLE cycle.
    acc_hits = 0; acc2 = -1;
    for (int n = 1; n <= 3 * (T_B + 1); n++) begin
      start = 1'b1;
      tick();
      if (b_acc_clr) begin
        acc_hits++;
        if (acc_hits == 2) acc2 = n;
      end
    end
    check("held.second_load_cycle", acc2, T_B + 2);
    start = 1'b0;
    repeat (T_B + 2) tick();

    // Extra start pulses inside a running job and in DONE are ignored.
    nrdy = 0;
    for (int k = 0; k <= T_B + 4; k++) begin
      start = (k == 0 || k == 3 || k == 10 || k == T_B);
      tick();
      if (b_ready) nrdy++;
    end
    check("ignored_starts.ready_count", nrdy, 1);
    start = 1'b0;

    // Reset during STREAM aborts the job without ready, then a fresh job runs.
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 2; n <= 9; n++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort.busy", b_busy ? 1 : 0, 0);
    nrdy = 0;
    for (int n = 0; n < T_B + 2; n++) begin
      tick();
      if (b_ready) nrdy++;
    end
    check("abort.no_ready", nrdy, 0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (T_B + 2) tick();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      start = ($urandom_range(0, 99) < 25);
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (T_B + 2) tick();
    check("total.ready_count", dut_rdy, mod_rdy);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
